// File: rtl/buzzer_sequencer.sv
// Shares one buzzer pin among four tone sources (key, tick, fail, ok) with fixed
// priority, one-deep pending queue per source, preemption and per-tone square waves.
module buzzer_sequencer #(
  parameter int CNT_W     = 32,
  parameter int KEY_HALF  = 50000,
  parameter int KEY_LEN   = 10000000,
  parameter int TICK_HALF = 100000,
  parameter int TICK_LEN  = 5000000,
  parameter int FAIL_HALF = 100000,
  parameter int FAIL_LEN  = 15000000,
  parameter int FAIL_GLO  = 5000000,
  parameter int FAIL_GHI  = 10000000,
  parameter int OK_HALF   = 25000,
  parameter int OK_LEN    = 30000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_key,
  input  logic       req_tick,
  input  logic       req_fail,
  input  logic       req_ok,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] active_id,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  localparam logic [2:0] ID_NONE = 3'd0;
  localparam logic [2:0] ID_KEY  = 3'd1;
  localparam logic [2:0] ID_TICK = 3'd2;
  localparam logic [2:0] ID_FAIL = 3'd3;
  localparam logic [2:0] ID_OK   = 3'd4;

  localparam logic [CNT_W-1:0] KEY_HL  = CNT_W'(KEY_HALF - 1);
  localparam logic [CNT_W-1:0] KEY_LL  = CNT_W'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0] TICK_HL = CNT_W'(TICK_HALF - 1);
  localparam logic [CNT_W-1:0] TICK_LL = CNT_W'(TICK_LEN - 1);
  localparam logic [CNT_W-1:0] FAIL_HL = CNT_W'(FAIL_HALF - 1);
  localparam logic [CNT_W-1:0] FAIL_LL = CNT_W'(FAIL_LEN - 1);
  localparam logic [CNT_W-1:0] OK_HL   = CNT_W'(OK_HALF - 1);
  localparam logic [CNT_W-1:0] OK_LL   = CNT_W'(OK_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LO  = CNT_W'(FAIL_GLO);
  localparam logic [CNT_W-1:0] GAP_HI  = CNT_W'(FAIL_GHI);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_n;
  logic [2:0]       r_active, w_active_n;
  logic [CNT_W-1:0] r_dur, w_dur_n;
  logic [CNT_W-1:0] r_half, w_half_n;
  logic             r_phase, w_phase_n;
  logic [3:0]       r_pending, w_pending_n;
  logic             r_buzzer, w_buzzer_n;

  logic [3:0]       w_req;
  logic [3:0]       w_eff;
  logic [2:0]       w_top_rank;
  logic [2:0]       w_top_id;
  logic [2:0]       w_act_rank;
  logic             w_gap;

  // Rank 4..1 follows ok > fail > key > tick; it is also bit index + 1 in w_eff.
  function automatic logic [2:0] rank_of(input logic [2:0] id);
    case (id)
      ID_OK:   rank_of = 3'd4;
      ID_FAIL: rank_of = 3'd3;
      ID_KEY:  rank_of = 3'd2;
      ID_TICK: rank_of = 3'd1;
      default: rank_of = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] id_of_rank(input logic [2:0] rank);
    case (rank)
      3'd4:    id_of_rank = ID_OK;
      3'd3:    id_of_rank = ID_FAIL;
      3'd2:    id_of_rank = ID_KEY;
      3'd1:    id_of_rank = ID_TICK;
      default: id_of_rank = ID_NONE;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] id);
    case (id)
      ID_OK:   mask_of = 4'b1000;
      ID_FAIL: mask_of = 4'b0100;
      ID_KEY:  mask_of = 4'b0010;
      ID_TICK: mask_of = 4'b0001;
      default: mask_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] half_last(input logic [2:0] id);
    case (id)
      ID_OK:   half_last = OK_HL;
      ID_FAIL: half_last = FAIL_HL;
      ID_KEY:  half_last = KEY_HL;
      ID_TICK: half_last = TICK_HL;
      default: half_last = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] len_last(input logic [2:0] id);
    case (id)
      ID_OK:   len_last = OK_LL;
      ID_FAIL: len_last = FAIL_LL;
      ID_KEY:  len_last = KEY_LL;
      ID_TICK: len_last = TICK_LL;
      default: len_last = '0;
    endcase
  endfunction

  assign w_req = {req_ok, req_fail, req_key, req_tick};
  assign w_eff = r_pending | w_req;

  always_comb begin
    w_top_rank = 3'd0;
    if (w_eff[3])      w_top_rank = 3'd4;
    else if (w_eff[2]) w_top_rank = 3'd3;
    else if (w_eff[1]) w_top_rank = 3'd2;
    else if (w_eff[0]) w_top_rank = 3'd1;
  end

  assign w_top_id   = id_of_rank(w_top_rank);
  assign w_act_rank = rank_of(r_active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_active  <= ID_NONE;
      r_dur     <= '0;
      r_half    <= '0;
      r_phase   <= 1'b0;
      r_pending <= 4'b0000;
      r_buzzer  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_active  <= w_active_n;
      r_dur     <= w_dur_n;
      r_half    <= w_half_n;
      r_phase   <= w_phase_n;
      r_pending <= w_pending_n;
      r_buzzer  <= w_buzzer_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_active_n  = r_active;
    w_dur_n     = r_dur;
    w_half_n    = r_half;
    w_phase_n   = r_phase;
    w_pending_n = r_pending | w_req;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_eff != 4'b0000) begin
          w_state_n   = S_PLAY;
          w_active_n  = w_top_id;
          w_dur_n     = '0;
          w_half_n    = '0;
          w_phase_n   = 1'b1;
          w_pending_n = w_eff & ~mask_of(w_top_id);
        end else begin
          w_state_n  = S_IDLE;
          w_active_n = ID_NONE;
          w_dur_n    = '0;
          w_half_n   = '0;
          w_phase_n  = 1'b0;
        end
      end
      S_PLAY: begin
        // Preemption beats retrigger, which beats normal end of tone.
        if (w_top_rank > w_act_rank) begin
          w_active_n  = w_top_id;
          w_dur_n     = '0;
          w_half_n    = '0;
          w_phase_n   = 1'b1;
          w_pending_n = w_eff & ~mask_of(w_top_id);
        end else if ((w_req & mask_of(r_active)) != 4'b0000) begin
          w_dur_n     = '0;
          w_half_n    = '0;
          w_phase_n   = 1'b1;
          w_pending_n = w_eff & ~mask_of(r_active);
        end else if (r_dur == len_last(r_active)) begin
          w_state_n = S_DONE;
        end else begin
          w_dur_n = r_dur + CNT_ONE;
          if (r_half == half_last(r_active)) begin
            w_half_n  = '0;
            w_phase_n = ~r_phase;
          end else begin
            w_half_n = r_half + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_active_n = ID_NONE;
      end
    endcase
  end

  // Gap is judged on the counter value the register will hold next cycle.
  assign w_gap = (w_active_n == ID_FAIL) && (w_dur_n >= GAP_LO) && (w_dur_n < GAP_HI);
  assign w_buzzer_n = (w_state_n == S_PLAY) & w_phase_n & ~mute & ~w_gap;

  assign buzzer    = r_buzzer;
  assign busy      = (r_state == S_PLAY);
  assign done      = (r_state == S_DONE);
  assign active_id = r_active;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with short sim parameters; outputs are
// sampled on the falling edge as {buzzer, busy, done, active_id}.
module tb_buzzer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_key, req_tick, req_fail, req_ok, mute;
  logic       buzzer, busy, done;
  logic [2:0] active_id;

  int checks = 0;
  int errors = 0;
  logic [5:0] obs, exp;

  buzzer_sequencer #(
    .CNT_W(32), .KEY_HALF(2), .KEY_LEN(12), .TICK_HALF(3), .TICK_LEN(9),
    .FAIL_HALF(1), .FAIL_LEN(10), .FAIL_GLO(3), .FAIL_GHI(6),
    .OK_HALF(1), .OK_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .req_key(req_key), .req_tick(req_tick),
    .req_fail(req_fail), .req_ok(req_ok), .mute(mute),
    .buzzer(buzzer), .busy(busy), .active_id(active_id), .done(done)
  );

  always #5 clk = ~clk;

  // Expected square wave per tone at duration index d (sim parameters).
  function automatic logic tone_bit(input logic [2:0] id, input int d);
    case (id)
      3'd1:    return (d % 4) < 2;
      3'd2:    return (d % 6) < 3;
      3'd3:    return ((d % 2) == 0) && !(d >= 3 && d < 6);
      3'd4:    return (d % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_key = 0; req_tick = 0; req_fail = 0; req_ok = 0; mute = 0;
    @(negedge clk);
    obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_hold got %b expected %b", obs, exp); end
    rst = 1'b0;
    @(negedge clk);
    obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_idle got %b expected %b", obs, exp); end
  endtask

  task automatic test_key(input logic muted);
    mute = muted;
    req_key = 1'b1;
    @(negedge clk);
    req_key = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs = {buzzer, busy, done, active_id};
      exp = {tone_bit(3'd1, i) & ~muted, 1'b1, 1'b0, 3'd1}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL key_play[%0d] mute=%0b got %b expected %b", i, muted, obs, exp); end
      @(negedge clk);
    end
    obs = {buzzer, busy, done, active_id}; exp = {3'b001, 3'd1}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL key_done mute=%0b got %b expected %b", muted, obs, exp); end
    @(negedge clk);
    obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL key_idle mute=%0b got %b expected %b", muted, obs, exp); end
    mute = 1'b0;
  endtask

  task automatic test_fail();
    logic [9:0] pat;
    pat = 10'b1010001010;
    req_fail = 1'b1;
    @(negedge clk);
    req_fail = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {pat[9 - i], 1'b1, 1'b0, 3'd3}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL fail_play[%0d] got %b expected %b", i, obs, exp); end
      @(negedge clk);
    end
    obs = {buzzer, busy, done, active_id}; exp = {3'b001, 3'd3}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL fail_done got %b expected %b", obs, exp); end
    @(negedge clk);
  endtask

  task automatic test_preempt();
    req_tick = 1'b1;
    @(negedge clk);
    req_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {tone_bit(3'd2, i), 2'b10, 3'd2}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL pre_tick[%0d] got %b expected %b", i, obs, exp); end
      if (i == 4) req_ok = 1'b1;
      @(negedge clk);
    end
    req_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {tone_bit(3'd4, i), 2'b10, 3'd4}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL pre_ok[%0d] got %b expected %b", i, obs, exp); end
      @(negedge clk);
    end
    obs = {buzzer, busy, done, active_id}; exp = {3'b001, 3'd4}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL pre_done got %b expected %b", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
      if (obs !== exp) begin errors++; $display("FAIL pre_no_resume[%0d] got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ids [3];
    int         lens [3];
    int         dones;
    ids[0] = 3'd4; ids[1] = 3'd1; ids[2] = 3'd2;
    lens[0] = 8;   lens[1] = 12;  lens[2] = 9;
    dones = 0;
    req_ok = 1'b1; req_key = 1'b1; req_tick = 1'b1;
    @(negedge clk);
    req_ok = 1'b0; req_key = 1'b0; req_tick = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < lens[t]; i++) begin
        obs = {buzzer, busy, done, active_id}; exp = {tone_bit(ids[t], i), 2'b10, ids[t]}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL b2b_tone%0d[%0d] got %b expected %b", t, i, obs, exp); end
        @(negedge clk);
      end
      if (done === 1'b1) dones++;
      obs = {buzzer, busy, done, active_id}; exp = {3'b001, ids[t]}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_done%0d got %b expected %b", t, obs, exp); end
      @(negedge clk);
    end
    obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL b2b_idle got %b expected %b", obs, exp); end
    checks++;
    if (dones !== 3) begin errors++; $display("FAIL b2b_done_count got %0d expected 3", dones); end
  endtask

  task automatic test_retrigger();
    req_key = 1'b1;
    @(negedge clk);
    req_key = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {tone_bit(3'd1, i), 2'b10, 3'd1}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL retrig_first[%0d] got %b expected %b", i, obs, exp); end
      if (i == 7) req_key = 1'b1;
      @(negedge clk);
    end
    req_key = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {tone_bit(3'd1, i), 2'b10, 3'd1}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL retrig_again[%0d] got %b expected %b", i, obs, exp); end
      @(negedge clk);
    end
    obs = {buzzer, busy, done, active_id}; exp = {3'b001, 3'd1}; checks++;
    if (obs !== exp) begin errors++; $display("FAIL retrig_done got %b expected %b", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
      if (obs !== exp) begin errors++; $display("FAIL retrig_single_done[%0d] got %b expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_async_reset();
    req_key = 1'b1; req_tick = 1'b1;
    @(negedge clk);
    req_key = 1'b0; req_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs = {buzzer, busy, done, active_id}; exp = {tone_bit(3'd1, i), 2'b10, 3'd1}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL rst_pre[%0d] got %b expected %b", i, obs, exp); end
      if (i == 0) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
    if (obs !== exp) begin errors++; $display("FAIL rst_async got %b expected %b", obs, exp); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = {buzzer, busy, done, active_id}; exp = 6'b0; checks++;
      if (obs !== exp) begin errors++; $display("FAIL rst_pending_cleared[%0d] got %b expected %b", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_key(1'b0);
    test_fail();
    test_preempt();
    test_back_to_back();
    test_retrigger();
    test_key(1'b1);
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
